// File: rtl/layer_rr_scheduler.sv
// Round-robin time-share of one fully-connected layer stream among R requesters.
// A grant covers one whole vector: N words in (LOAD), then M words back out (DRAIN).
module layer_rr_scheduler #(
  parameter int R = 4,
  parameter int N = 2,
  parameter int M = 5,
  parameter int T = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [R-1:0]         s_valid,
  input  logic [R*T-1:0]       s_data,
  output logic [R-1:0]         s_ready,
  output logic [R-1:0]         m_valid,
  output logic [T-1:0]         m_data,
  input  logic [R-1:0]         m_ready,
  output logic                 l_s_valid,
  output logic [T-1:0]         l_data_in,
  input  logic                 l_s_ready,
  input  logic                 l_m_valid,
  input  logic [T-1:0]         l_data_out,
  output logic                 l_m_ready,
  output logic [$clog2(R)-1:0] owner,
  output logic                 busy,
  output logic                 err
);

  localparam int OW  = $clog2(R);
  localparam int ICW = $clog2(N + 1);
  localparam int OCW = $clog2(M + 1);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [OW-1:0]  owner_q, owner_d;
  logic [OW-1:0]  last_q, last_d;
  logic [ICW-1:0] in_cnt_q, in_cnt_d;
  logic [OCW-1:0] out_cnt_q, out_cnt_d;
  logic           err_q, err_d;

  logic           grant_found;
  logic [OW-1:0]  grant_idx;
  logic           in_fire, out_fire, in_last, out_last;

  // Search starts just after the previous owner so every waiting requester
  // is reached within R-1 vectors.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= R; k++) begin
      int c;
      c = int'(last_q) + k;
      if (c >= R) c = c - R;
      if (!grant_found && s_valid[c[OW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = c[OW-1:0];
      end
    end
  end

  assign in_fire  = l_s_valid && l_s_ready;
  assign out_fire = l_m_valid && l_m_ready;
  assign in_last  = (in_cnt_q == ICW'(N - 1));
  assign out_last = (out_cnt_q == OCW'(M - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output is given a default before any branch,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_found)         state_d = LOAD;
      LOAD:    if (in_fire && in_last)   state_d = DRAIN;
      DRAIN:   if (out_fire && out_last) state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = '0;
    m_valid   = '0;
    l_s_valid = 1'b0;
    l_m_ready = 1'b0;
    unique case (state_q)
      LOAD: begin
        l_s_valid        = s_valid[owner_q];
        s_ready[owner_q] = l_s_ready;
      end
      DRAIN: begin
        m_valid[owner_q] = l_m_valid;
        l_m_ready        = m_ready[owner_q];
      end
      default: ;
    endcase
  end

  assign l_data_in = s_data[int'(owner_q)*T +: T];
  assign m_data    = l_data_out;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

  always_comb begin
    owner_d   = owner_q;
    last_d    = last_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    // Layer output is only legitimate while draining; anything else is sticky.
    err_d     = err_q | (l_m_valid && (state_q != DRAIN));
    if ((state_q == IDLE) && grant_found) owner_d = grant_idx;
    if (in_fire) in_cnt_d = in_last ? '0 : in_cnt_q + ICW'(1);
    if (out_fire) begin
      out_cnt_d = out_last ? '0 : out_cnt_q + OCW'(1);
      if (out_last) last_d = owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= '0;
      last_q    <= OW'(R - 1);
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_layer_rr_scheduler.sv
// Scoreboard bench for layer_rr_scheduler with a small behavioural 5x2 layer partner.
// Requester r always sends its own fixed vector, so each output word identifies its source.
module tb_layer_rr_scheduler;

  localparam int R = 4;
  localparam int N = 2;
  localparam int M = 5;
  localparam int T = 9;

  typedef struct {
    int             req;
    logic [T-1:0]   data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [R-1:0]         s_valid, s_ready, m_valid, m_ready;
  logic [R*T-1:0]       s_data;
  logic [T-1:0]         m_data, l_data_in, l_data_out;
  logic                 l_s_valid, l_s_ready, l_m_valid, l_m_ready;
  logic [$clog2(R)-1:0] owner;
  logic                 busy, err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pend[R];
  int   widx[R];
  logic toggle_mode;
  logic force_mv;

  always #5 clk = ~clk;

  layer_rr_scheduler #(.R(R), .N(N), .M(M), .T(T)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .l_s_valid(l_s_valid), .l_data_in(l_data_in), .l_s_ready(l_s_ready),
    .l_m_valid(l_m_valid), .l_data_out(l_data_out), .l_m_ready(l_m_ready),
    .owner(owner), .busy(busy), .err(err)
  );

  // Partner layer: relu(W*x) with W rows (1,4) (2,0) (-1,-1) (0,-3) (2,4).
  function automatic logic [T-1:0] lay_fn(int k, logic [T-1:0] a, logic [T-1:0] b);
    int x0, x1, y;
    x0 = int'(a);
    x1 = int'(b);
    case (k)
      0:       y = x0 + 4 * x1;
      1:       y = 2 * x0;
      2:       y = -x0 - x1;
      3:       y = -3 * x1;
      default: y = 2 * x0 + 4 * x1;
    endcase
    if (y < 0) y = 0;
    return T'(y);
  endfunction

  logic         lay_out_ph;
  int           lay_in_i, lay_out_i;
  logic [T-1:0] lay_x[N];

  always @(posedge clk) begin
    if (reset) begin
      lay_out_ph <= 1'b0;
      lay_in_i   <= 0;
      lay_out_i  <= 0;
    end else if (!lay_out_ph) begin
      if (l_s_valid) begin
        lay_x[lay_in_i] <= l_data_in;
        if (lay_in_i == N - 1) begin
          lay_in_i   <= 0;
          lay_out_ph <= 1'b1;
        end else begin
          lay_in_i <= lay_in_i + 1;
        end
      end
    end else if (l_m_ready) begin
      if (lay_out_i == M - 1) begin
        lay_out_i  <= 0;
        lay_out_ph <= 1'b0;
      end else begin
        lay_out_i <= lay_out_i + 1;
      end
    end
  end

  assign l_s_ready  = !lay_out_ph;
  assign l_m_valid  = lay_out_ph | force_mv;
  assign l_data_out = lay_fn(lay_out_i, lay_x[0], lay_x[1]);

  function automatic logic [T-1:0] vec_x(int r, int w);
    int tbl[R][N] = '{'{1, 2}, '{3, 1}, '{2, 3}, '{4, 0}};
    return T'(tbl[r][w]);
  endfunction

  // Hand-computed layer outputs for each requester's vector.
  function automatic logic [T-1:0] exp_y(int r, int k);
    int tbl[R][M] = '{'{9, 2, 0, 0, 10}, '{7, 6, 0, 0, 10},
                      '{14, 4, 0, 0, 16}, '{4, 8, 0, 0, 8}};
    return T'(tbl[r][k]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_vec(input int r);
    exp_t e;
    for (int k = 0; k < M; k++) begin
      e.req  = r;
      e.data = exp_y(r, k);
      exp_q.push_back(e);
    end
  endtask

  function automatic int pend_sum();
    int s = 0;
    for (int i = 0; i < R; i++) s += pend[i];
    return s;
  endfunction

  task automatic drive_s();
    for (int i = 0; i < R; i++) begin
      s_valid[i]       = (pend[i] > 0);
      s_data[i*T +: T] = (pend[i] > 0) ? vec_x(i, widx[i]) : '0;
    end
  endtask

  // Requester driver: handshakes seen before the edge advance the word pointers.
  initial begin
    logic [R-1:0] fire;
    forever begin
      @(negedge clk);
      fire = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < R; i++) begin
        if (reset) begin
          pend[i] = 0;
          widx[i] = 0;
        end else if (fire[i]) begin
          widx[i]++;
          if (widx[i] == N) begin
            widx[i] = 0;
            pend[i]--;
          end
        end
      end
      m_ready = toggle_mode ? ~m_ready : '1;
      drive_s();
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    logic [R-1:0] hold_v;
    logic [T-1:0] hold_data;
    exp_t         e;
    hold_v    = '0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold_v = '0;
      end else begin
        if (hold_v != '0) begin
          check("hold_valid", 32'(m_valid & hold_v), 32'(hold_v));
          check("hold_data", 32'(m_data), 32'(hold_data));
        end
        if (!busy) check("idle_s_ready", 32'(s_ready), 0);
        if (m_valid != '0) begin
          if (exp_q.size() == 0) check("spurious_m_valid", 32'(m_valid), 0);
          else                   check("m_valid_onehot", 32'(m_valid), 32'(1 << exp_q[0].req));
        end
        hold_v = '0;
        for (int i = 0; i < R; i++) begin
          if (m_valid[i] && exp_q.size() != 0) begin
            if (m_ready[i]) begin
              e = exp_q.pop_front();
              check("out_req", 32'(i), 32'(e.req));
              check("out_data", 32'(m_data), 32'(e.data));
            end else begin
              hold_v[i] = 1'b1;
              hold_data = m_data;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (cyc < 400 && !(exp_q.size() == 0 && !busy && pend_sum() == 0)) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_complete"}, 32'(cyc < 400), 1);
    if (cyc >= 400) exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int cyc;
    reset       = 1'b1;
    s_valid     = '0;
    s_data      = '0;
    m_ready     = '1;
    force_mv    = 1'b0;
    toggle_mode = 1'b0;
    for (int i = 0; i < R; i++) begin
      pend[i] = 0;
      widx[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_err", 32'(err), 0);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_l_s_valid", 32'(l_s_valid), 0);
    check("rst_l_m_ready", 32'(l_m_ready), 0);
    reset = 1'b0;

    // Single vector from requester 0.
    @(negedge clk);
    push_vec(0);
    pend[0] = 1;
    wait_idle("t1");
    check("t1_owner", 32'(owner), 0);
    check("t1_busy", 32'(busy), 0);

    // Simultaneous requests 1 and 2 from reset: 1 first, then 2, no interleave.
    do_reset();
    push_vec(1);
    push_vec(2);
    pend[1] = 1;
    pend[2] = 1;
    wait_idle("t2");
    check("t2_owner", 32'(owner), 2);

    // All four hold valid for two vectors each: order 0,1,2,3,0,1,2,3.
    do_reset();
    for (int v = 0; v < 2 * R; v++) push_vec(v % R);
    for (int i = 0; i < R; i++) pend[i] = 2;
    wait_idle("t3");

    // Output backpressure toggling during DRAIN.
    @(negedge clk);
    toggle_mode = 1'b1;
    push_vec(2);
    pend[2] = 1;
    wait_idle("t4");
    toggle_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Reset after the first input word of requester 3 aborts the vector.
    do_reset();
    pend[3] = 1;
    cyc = 0;
    while (cyc < 50 && widx[3] != 1) begin
      @(negedge clk);
      cyc++;
    end
    check("t5_first_word", 32'(cyc < 50), 1);
    check("t5_busy_loading", 32'(busy), 1);
    check("t5_owner_loading", 32'(owner), 3);
    reset = 1'b1;
    @(negedge clk);
    check("t5_busy_after_rst", 32'(busy), 0);
    check("t5_owner_after_rst", 32'(owner), 0);
    reset = 1'b0;
    push_vec(0);
    push_vec(3);
    pend[0] = 1;
    pend[3] = 1;
    wait_idle("t5");

    // Layer output while idle sets sticky err and reaches no requester.
    do_reset();
    force_mv = 1'b1;
    check("t6_err_before", 32'(err), 0);
    @(negedge clk);
    check("t6_m_valid", 32'(m_valid), 0);
    check("t6_err_set", 32'(err), 1);
    force_mv = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_err_sticky", 32'(err), 1);
    check("t6_busy", 32'(busy), 0);
    do_reset();
    @(negedge clk);
    check("t6_err_cleared", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
